// File: rtl/cpx_accumulate_if.sv
// Sample-in / block-sum-out handshake bundle for cpx_accumulate.
// Upstream pushes i/q samples; downstream takes one complex sum per block.
interface cpx_accumulate_if #(
    parameter int i_bits     = 24,
    parameter int q_bits     = 24,
    parameter int sum_i_bits = 32,
    parameter int sum_q_bits = 32,
    parameter int cnt_bits   = 16
);
    logic                  m_axis_tvalid;
    logic                  s_axis_tready;
    logic [i_bits-1:0]     i;
    logic [q_bits-1:0]     q;
    logic                  m_axis_tready;
    logic                  s_axis_tvalid;
    logic [sum_i_bits-1:0] sum_i;
    logic [sum_q_bits-1:0] sum_q;
    logic                  overflow;
    logic [cnt_bits-1:0]   count;

    modport slave (
        input  m_axis_tvalid,
        input  i,
        input  q,
        input  m_axis_tready,
        output s_axis_tready,
        output s_axis_tvalid,
        output sum_i,
        output sum_q,
        output overflow,
        output count
    );

    modport master (
        output m_axis_tvalid,
        output i,
        output q,
        output m_axis_tready,
        input  s_axis_tready,
        input  s_axis_tvalid,
        input  sum_i,
        input  sum_q,
        input  overflow,
        input  count
    );
endinterface

// File: rtl/cpx_accumulate.sv
// Coherent complex accumulator: sums acc_len accepted i/q samples per block
// and hands one sum downstream, holding it until accepted.
module cpx_accumulate #(
    parameter int i_bits     = 24,
    parameter int q_bits     = 24,
    parameter int sum_i_bits = 32,
    parameter int sum_q_bits = 32,
    parameter int acc_len    = 64,
    parameter int cnt_bits   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    cpx_accumulate_if.slave bus
);
    typedef enum logic [1:0] {
        INIT,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [cnt_bits-1:0] LAST = cnt_bits'(acc_len - 1);

    state_t state;
    state_t state_n;

    logic signed [i_bits-1:0]     in_i;
    logic signed [q_bits-1:0]     in_q;
    logic signed [sum_i_bits-1:0] ext_i;
    logic signed [sum_q_bits-1:0] ext_q;
    logic signed [sum_i_bits-1:0] acc_i;
    logic signed [sum_q_bits-1:0] acc_q;
    logic signed [sum_i_bits-1:0] nxt_i;
    logic signed [sum_q_bits-1:0] nxt_q;
    logic [sum_i_bits-1:0]        sum_i_r;
    logic [sum_q_bits-1:0]        sum_q_r;
    logic [cnt_bits-1:0]          cnt;

    logic flag;
    logic ovf_r;
    logic ov_i;
    logic ov_q;
    logic rdy;
    logic rdy_n;
    logic vld;
    logic vld_n;
    logic beat;
    logic last;
    logic load;
    logic acc_en;
    logic acc_clr;

    // signed-to-wider assignment does the sign extension
    assign in_i  = bus.i;
    assign in_q  = bus.q;
    assign ext_i = in_i;
    assign ext_q = in_q;

    assign nxt_i = acc_i + ext_i;
    assign nxt_q = acc_q + ext_q;

    assign ov_i = (acc_i[sum_i_bits-1] == ext_i[sum_i_bits-1]) &&
                  (nxt_i[sum_i_bits-1] != acc_i[sum_i_bits-1]);
    assign ov_q = (acc_q[sum_q_bits-1] == ext_q[sum_q_bits-1]) &&
                  (nxt_q[sum_q_bits-1] != acc_q[sum_q_bits-1]);

    assign beat = bus.m_axis_tvalid & rdy;
    assign last = (cnt == LAST);

    always_comb begin
        state_n = state;
        rdy_n   = rdy;
        vld_n   = vld;
        load    = 1'b0;
        acc_en  = 1'b0;
        acc_clr = 1'b0;
        unique case (state)
            INIT: begin
                state_n = ACCUM;
                rdy_n   = 1'b1;
            end
            ACCUM: begin
                if (clear) begin
                    acc_clr = 1'b1;
                    rdy_n   = 1'b1;
                    vld_n   = 1'b0;
                end else if (beat) begin
                    if (last) begin
                        load    = 1'b1;
                        acc_clr = 1'b1;
                        rdy_n   = 1'b0;
                        vld_n   = 1'b1;
                        state_n = HOLD;
                    end else begin
                        acc_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                // clear drops a pending sum without handing it off
                if (clear) begin
                    acc_clr = 1'b1;
                    rdy_n   = 1'b1;
                    vld_n   = 1'b0;
                    state_n = ACCUM;
                end else if (vld && bus.m_axis_tready) begin
                    rdy_n   = 1'b1;
                    vld_n   = 1'b0;
                    state_n = ACCUM;
                end
            end
            default: begin
                state_n = INIT;
                rdy_n   = 1'b0;
                vld_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            rdy   <= 1'b0;
            vld   <= 1'b0;
        end else begin
            state <= state_n;
            rdy   <= rdy_n;
            vld   <= vld_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_i <= '0;
            acc_q <= '0;
            flag  <= 1'b0;
            cnt   <= '0;
        end else if (acc_clr) begin
            acc_i <= '0;
            acc_q <= '0;
            flag  <= 1'b0;
            cnt   <= '0;
        end else if (acc_en) begin
            acc_i <= nxt_i;
            acc_q <= nxt_q;
            flag  <= flag | ov_i | ov_q;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_i_r <= '0;
            sum_q_r <= '0;
            ovf_r   <= 1'b0;
        end else if (load) begin
            sum_i_r <= nxt_i;
            sum_q_r <= nxt_q;
            ovf_r   <= flag | ov_i | ov_q;
        end
    end

    assign bus.s_axis_tready = rdy;
    assign bus.s_axis_tvalid = vld;
    assign bus.sum_i         = sum_i_r;
    assign bus.sum_q         = sum_q_r;
    assign bus.overflow      = ovf_r;
    assign bus.count         = cnt;
endmodule

// File: tb/tb_cpx_accumulate.sv
// Scoreboard bench for cpx_accumulate: four instances cover
// acc_len 4/2/8/1, 24-bit wrap, clear and async reset.
module tb_cpx_accumulate;
    logic clk;
    logic rst_n;
    logic clr4;
    logic clr2;
    logic clr8;
    logic clr1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] si;
        logic [31:0] sq;
        logic        ov;
    } exp_t;

    exp_t        sb[4][$];
    logic [31:0] macc_i[4];
    logic [31:0] macc_q[4];
    logic        mov[4];
    int          mcnt[4];
    int          wid[4] = '{32, 24, 32, 32};
    int          len[4] = '{4, 2, 8, 1};

    cpx_accumulate_if b4 ();
    cpx_accumulate_if #(.sum_i_bits(24), .sum_q_bits(24)) b2 ();
    cpx_accumulate_if b8 ();
    cpx_accumulate_if b1 ();

    cpx_accumulate #(.acc_len(4)) u4 (
        .clk(clk), .rst_n(rst_n), .clear(clr4), .bus(b4.slave)
    );
    cpx_accumulate #(.sum_i_bits(24), .sum_q_bits(24), .acc_len(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clr2), .bus(b2.slave)
    );
    cpx_accumulate #(.acc_len(8)) u8 (
        .clk(clk), .rst_n(rst_n), .clear(clr8), .bus(b8.slave)
    );
    cpx_accumulate #(.acc_len(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clr1), .bus(b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic mclr(input int k);
        macc_i[k] = '0;
        macc_q[k] = '0;
        mov[k]    = 1'b0;
        mcnt[k]   = 0;
    endtask

    task automatic mbeat(input int k, input int vi, input int vq);
        logic signed [23:0] ti;
        logic signed [23:0] tq;
        logic [31:0] si, sq, ni, nq, mask;
        int w;
        w    = wid[k];
        mask = 32'((64'd1 << w) - 64'd1);
        ti   = vi[23:0];
        tq   = vq[23:0];
        si   = 32'(ti) & mask;
        sq   = 32'(tq) & mask;
        ni   = (macc_i[k] + si) & mask;
        nq   = (macc_q[k] + sq) & mask;
        if ((macc_i[k][w-1] == si[w-1]) && (ni[w-1] != si[w-1])) mov[k] = 1'b1;
        if ((macc_q[k][w-1] == sq[w-1]) && (nq[w-1] != sq[w-1])) mov[k] = 1'b1;
        mcnt[k]++;
        if (mcnt[k] == len[k]) begin
            sb[k].push_back('{ni, nq, mov[k]});
            mclr(k);
        end else begin
            macc_i[k] = ni;
            macc_q[k] = nq;
        end
    endtask

    task automatic drv(input int k, input logic v, input int vi, input int vq);
        case (k)
            0: begin b4.m_axis_tvalid = v; b4.i = vi[23:0]; b4.q = vq[23:0]; end
            1: begin b2.m_axis_tvalid = v; b2.i = vi[23:0]; b2.q = vq[23:0]; end
            2: begin b8.m_axis_tvalid = v; b8.i = vi[23:0]; b8.q = vq[23:0]; end
            default: begin b1.m_axis_tvalid = v; b1.i = vi[23:0]; b1.q = vq[23:0]; end
        endcase
    endtask

    function automatic logic rdy(input int k);
        case (k)
            0: return b4.s_axis_tready;
            1: return b2.s_axis_tready;
            2: return b8.s_axis_tready;
            default: return b1.s_axis_tready;
        endcase
    endfunction

    // returns at posedge+1 just after the beat's accepting edge
    task automatic send(input int k, input int vi, input int vq);
        logic ok;
        ok = 1'b0;
        drv(k, 1'b1, vi, vq);
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = rdy(k);
            @(posedge clk);
            #1;
        end
        drv(k, 1'b0, 0, 0);
        if (ok) mbeat(k, vi, vq);
        else chk($sformatf("u%0d beat accepted", k), 64'(ok), 64'd1);
    endtask

    task automatic take(input int k, input logic [31:0] si,
                        input logic [31:0] sq, input logic ov);
        exp_t e;
        if (sb[k].size() == 0) begin
            chk($sformatf("u%0d unexpected sum", k), 64'(sb[k].size()), 64'd1);
            return;
        end
        e = sb[k].pop_front();
        chk($sformatf("u%0d sb sum_i", k), 64'(si), 64'(e.si));
        chk($sformatf("u%0d sb sum_q", k), 64'(sq), 64'(e.sq));
        chk($sformatf("u%0d sb overflow", k), 64'(ov), 64'(e.ov));
    endtask

    always @(negedge clk)
        if (b4.s_axis_tvalid && b4.m_axis_tready)
            take(0, b4.sum_i, b4.sum_q, b4.overflow);
    always @(negedge clk)
        if (b2.s_axis_tvalid && b2.m_axis_tready)
            take(1, 32'(b2.sum_i), 32'(b2.sum_q), b2.overflow);
    always @(negedge clk)
        if (b8.s_axis_tvalid && b8.m_axis_tready)
            take(2, b8.sum_i, b8.sum_q, b8.overflow);
    always @(negedge clk)
        if (b1.s_axis_tvalid && b1.m_axis_tready)
            take(3, b1.sum_i, b1.sum_q, b1.overflow);

    initial begin
        rst_n = 1'b0;
        clr4  = 1'b0;
        clr2  = 1'b0;
        clr8  = 1'b0;
        clr1  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mclr(k);
            drv(k, 1'b0, 0, 0);
        end
        b4.m_axis_tready = 1'b1;
        b2.m_axis_tready = 1'b1;
        b8.m_axis_tready = 1'b1;
        b1.m_axis_tready = 1'b1;

        #2;
        chk("rst tready", 64'(b4.s_axis_tready), 64'd0);
        chk("rst tvalid", 64'(b4.s_axis_tvalid), 64'd0);
        chk("rst sum_i", 64'(b4.sum_i), 64'd0);
        chk("rst sum_q", 64'(b4.sum_q), 64'd0);
        chk("rst overflow", 64'(b4.overflow), 64'd0);
        chk("rst count", 64'(b4.count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init tready", 64'(b4.s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        chk("accum tready", 64'(b4.s_axis_tready), 64'd1);

        // back-to-back block, downstream always ready
        for (int n = 1; n <= 4; n++) send(0, n, -n);
        chk("t1 tvalid", 64'(b4.s_axis_tvalid), 64'd1);
        chk("t1 tready low", 64'(b4.s_axis_tready), 64'd0);
        chk("t1 sum_i", 64'(b4.sum_i), 64'd10);
        chk("t1 sum_q", 64'(b4.sum_q), 64'hFFFF_FFF6);
        chk("t1 overflow", 64'(b4.overflow), 64'd0);
        @(posedge clk);
        #1;
        chk("t1 tvalid drop", 64'(b4.s_axis_tvalid), 64'd0);
        chk("t1 tready back", 64'(b4.s_axis_tready), 64'd1);

        // downstream stalls while upstream keeps offering a beat
        b4.m_axis_tready = 1'b0;
        for (int n = 5; n <= 8; n++) send(0, n, 0);
        drv(0, 1'b1, 100, 100);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t2 hold tvalid", 64'(b4.s_axis_tvalid), 64'd1);
            chk("t2 hold tready", 64'(b4.s_axis_tready), 64'd0);
            chk("t2 hold sum_i", 64'(b4.sum_i), 64'd26);
            chk("t2 hold count", 64'(b4.count), 64'd0);
            @(posedge clk);
            #1;
        end
        drv(0, 1'b0, 0, 0);
        b4.m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        chk("t2 tvalid drop", 64'(b4.s_axis_tvalid), 64'd0);
        chk("t2 tready back", 64'(b4.s_axis_tready), 64'd1);
        chk("t2 count", 64'(b4.count), 64'd0);
        for (int n = 0; n < 4; n++) send(0, 1, 1);
        chk("t2 next sum_i", 64'(b4.sum_i), 64'd4);

        // 24-bit accumulator wrap
        send(1, 32'h7F_FFFF, 0);
        send(1, 32'h7F_FFFF, 0);
        chk("t3 wrap sum_i", 64'(b2.sum_i), 64'hFF_FFFE);
        chk("t3 overflow", 64'(b2.overflow), 64'd1);
        @(posedge clk);
        #1;
        send(1, 3, -2);
        send(1, 4, 5);
        chk("t3 small sum_i", 64'(b2.sum_i), 64'd7);
        chk("t3 small sum_q", 64'(b2.sum_q), 64'd3);
        chk("t3 overflow clr", 64'(b2.overflow), 64'd0);

        // clear with a concurrent beat
        for (int n = 0; n < 5; n++) send(2, 10, 10);
        chk("t4 count pre", 64'(b8.count), 64'd5);
        clr8 = 1'b1;
        drv(2, 1'b1, 99, 99);
        @(posedge clk);
        #1;
        clr8 = 1'b0;
        drv(2, 1'b0, 0, 0);
        mclr(2);
        chk("t4 count clr", 64'(b8.count), 64'd0);
        chk("t4 tvalid", 64'(b8.s_axis_tvalid), 64'd0);
        chk("t4 tready", 64'(b8.s_axis_tready), 64'd1);
        for (int n = 0; n < 8; n++) send(2, 1, 0);
        chk("t4 sum_i", 64'(b8.sum_i), 64'd8);
        chk("t4 tvalid out", 64'(b8.s_axis_tvalid), 64'd1);

        // acc_len=1 with random gaps and signed data
        for (int n = 0; n < 100; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(3, int'($urandom_range(0, 32'hFF_FFFF)),
                 int'($urandom_range(0, 32'hFF_FFFF)));
        end
        repeat (3) @(posedge clk);
        #1;

        // async reset mid-block
        for (int n = 0; n < 3; n++) send(0, 7, 7);
        chk("t6 count pre", 64'(b4.count), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t6 rst tready", 64'(b4.s_axis_tready), 64'd0);
        chk("t6 rst tvalid", 64'(b4.s_axis_tvalid), 64'd0);
        chk("t6 rst sum_i", 64'(b4.sum_i), 64'd0);
        chk("t6 rst sum_q", 64'(b4.sum_q), 64'd0);
        chk("t6 rst count", 64'(b4.count), 64'd0);
        for (int k = 0; k < 4; k++) mclr(k);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 tready", 64'(b4.s_axis_tready), 64'd1);
        send(0, -5, 7);
        send(0, 1, 1);
        send(0, 2, 2);
        send(0, 3, 3);
        chk("t6 sum_i", 64'(b4.sum_i), 64'd1);
        chk("t6 sum_q", 64'(b4.sum_q), 64'd13);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("u%0d sb drained", k), 64'(sb[k].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpx_accumulate.md
Name: cpx_accumulate

Overview:
Stream consumer for complex products (i/q) from the complex multiplier; coherently sums acc_len consecutive accepted samples per block. Emits one complex sum per block with a valid/ready handshake and holds it until the downstream accepts it. Sits between the complex multiplier and the CAF peak search, forming one correlation lag/frequency bin.

Parameters:
i_bits, 24, width of signed input real part
q_bits, 24, width of signed input imaginary part
sum_i_bits, 32, width of signed real accumulator/output
sum_q_bits, 32, width of signed imaginary accumulator/output
acc_len, 64, samples per block (>=1)
cnt_bits, 16, sample counter width (2^cnt_bits >= acc_len)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort of current block
m_axis_tvalid  input  1  upstream sample valid
s_axis_tready  output  1  ready to accept sample (registered)
i  input  i_bits  signed real sample
q  input  q_bits  signed imaginary sample
m_axis_tready  input  1  downstream ready for sum
s_axis_tvalid  output  1  sum valid (registered)
sum_i  output  sum_i_bits  signed real block sum
sum_q  output  sum_q_bits  signed imaginary block sum
overflow  output  1  sticky-per-block: any signed overflow during this sum
count  output  cnt_bits  samples accepted in current block

Behaviour:
- Reset (rst_n=0, async): state INIT; s_axis_tready=0, s_axis_tvalid=0, sum_i=0, sum_q=0, overflow=0, count=0, accumulators=0.
- States: INIT -> ACCUM unconditionally on first clk after rst_n release; s_axis_tready becomes 1 on that edge.
- Beat accepted when m_axis_tvalid & s_axis_tready. i/q sign-extended to sum widths; acc <= acc + sample, two's-complement wrap, no saturation. Per-component overflow: both operands same sign, result sign differs; ORed into block overflow flag.
- ACCUM, accepted beat with count < acc_len-1: count+1, s_axis_tready stays 1.
- ACCUM, accepted beat with count == acc_len-1: sum_i/sum_q <= acc + sample, overflow <= flag including this beat; s_axis_tvalid=1 and s_axis_tready=0 on that same edge; acc, flag, count cleared; state HOLD. Latency: sum valid 1 cycle after last beat accepted.
- HOLD: s_axis_tready=0; sum_i/sum_q/overflow stable while s_axis_tvalid=1. On m_axis_tvalid ignored. When s_axis_tvalid & m_axis_tready: s_axis_tvalid=0, s_axis_tready=1 next edge, state ACCUM.
- Minimum period per block: acc_len+1 cycles (one bubble for output handoff).
- acc_len=1: every accepted beat goes straight to HOLD with sum = sign-extended sample.
- m_axis_tvalid low in ACCUM: no change; gaps allowed anywhere in block.
- clear=1 (any state except INIT): acc, flag, count cleared; s_axis_tvalid=0; s_axis_tready=1 next edge; state ACCUM; a pending HOLD sum is discarded; sum_i/sum_q retain old value. A beat handshaking in the same cycle as clear is consumed and discarded. clear beats all other events.
- rst_n asserted mid-block or in HOLD: immediate return to reset values; no partial output.

Test Plan:
- acc_len=4, m_axis_tready=1, samples (1,-1),(2,-2),(3,-3),(4,-4) back-to-back -> s_axis_tvalid one cycle after 4th beat, sum_i=10, sum_q=-10, overflow=0, s_axis_tready low exactly 1 cycle.
- acc_len=4, m_axis_tready=0 for 5 cycles after valid -> sum held stable, s_axis_tready=0, extra input beats not accepted; on m_axis_tready=1 valid drops next cycle, next block starts at count=0.
- sum_i_bits=24, i_bits=24, acc_len=2, i=0x7FFFFF twice -> sum_i=0xFFFFFE (wrap), overflow=1; following block with small values -> overflow=0.
- acc_len=8, assert clear after 5 beats with a concurrent beat -> count=0, no output, next 8 beats (all i=1) give sum_i=8.
- acc_len=1, random valid gaps, 100 samples -> 100 outputs each equal to sign-extended input, order preserved.
- rst_n low mid-block (count=3) -> all outputs 0 immediately; after release s_axis_tready=1 after one clk, fresh block sums correctly.
